// File: rtl/winner_policy_v3.sv
// winner_policy_v3 -- epsilon-greedy next-hop selector.
//
// Walks up to MAX_NBR neighbour entries (ID then Q-value) in the shared
// byte-addressed memory. It keeps the greedy best entry and also the entry
// at the round-robin index. At the end it either takes the exploratory
// round-robin hop or the greedy/own choice.
//
// Optional feature: define EPSILON_DECAY_EN to shrink epsilon by
// epsilon_step after every decision. Without it, epsilon changes only
// through load_eps.
//
// Ports:
//   clock, nreset          rising-edge clock, async active-low reset
//   start                  begin a decision (only looked at in IDLE)
//   load_eps, epsilon_in   load the 8-bit exploration threshold
//   epsilon_step           decay amount per decision (decay build only)
//   my_node_id, my_value   own ID and Q-value, latched at start
//   nbr_count              number of valid entries, clamped to MAX_NBR
//   address, mem_data_in   memory read port; data arrives one cycle later
//   nexthop, next_value    chosen hop and its Q-value
//   explored               last decision was exploratory
//   done                   one-cycle completion pulse
//   busy                   high outside IDLE
//   cstate                 current state encoding, for debug
module winner_policy_v3 #(
  parameter int                    WORD_WIDTH   = 16,
  parameter int                    MAX_NBR      = 64,
  parameter logic [WORD_WIDTH-1:0] NBR_BASE     = 16'h0048,
  parameter logic [WORD_WIDTH-1:0] QV_BASE      = 16'h01C8,
  parameter int                    ENTRY_STRIDE = 2,
  parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  load_eps,
  input  logic [7:0]            epsilon_in,
  input  logic [7:0]            epsilon_step,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] my_value,
  input  logic [WORD_WIDTH-1:0] nbr_count,
  output logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] mem_data_in,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic [WORD_WIDTH-1:0] next_value,
  output logic                  explored,
  output logic                  done,
  output logic                  busy,
  output logic [7:0]            cstate
);

  // One extra bit so that a count of exactly MAX_NBR is representable.
  localparam int IW = $clog2(MAX_NBR) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    RD_ID  = 3'd2,
    RD_Q   = 3'd3,
    CMP    = 3'd4,
    DECIDE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] my_id_q, my_id_d, my_val_q, my_val_d;
  logic [IW-1:0]         n_q, n_d, idx_q, idx_d, rr_idx_q, rr_idx_d;
  logic [WORD_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d, best_q_q, best_q_d;
  logic [WORD_WIDTH-1:0] rr_id_q, rr_id_d, rr_q_q, rr_q_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [7:0]            eps_q, eps_d;
  logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d, next_value_q, next_value_d;
  logic                  explored_q, explored_d;

  logic [IW-1:0]         idx_inc, rr_inc;
  logic                  explore;
  logic                  lfsr_fb;

`ifndef EPSILON_DECAY_EN
  logic unused_step;
  assign unused_step = ^epsilon_step;
`endif

  assign idx_inc = idx_q + IW'(1);
  assign rr_inc  = rr_idx_q + IW'(1);
  // Taps 16,14,13,11 of the Fibonacci polynomial, shifted in at bit 0.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d      = state_q;
    my_id_d      = my_id_q;
    my_val_d     = my_val_q;
    n_d          = n_q;
    idx_d        = idx_q;
    rr_idx_d     = rr_idx_q;
    cur_id_d     = cur_id_q;
    best_id_d    = best_id_q;
    best_q_d     = best_q_q;
    rr_id_d      = rr_id_q;
    rr_q_d       = rr_q_q;
    lfsr_d       = lfsr_q;
    eps_d        = eps_q;
    nexthop_d    = nexthop_q;
    next_value_d = next_value_q;
    explored_d   = explored_q;
    address      = '0;
    explore      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          my_id_d  = my_node_id;
          my_val_d = my_value;
          n_d      = (nbr_count > WORD_WIDTH'(MAX_NBR)) ? IW'(MAX_NBR)
                                                         : nbr_count[IW-1:0];
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // A neighbour list that shrank may leave rr_idx out of range;
        // restart the rotation so the scan can still capture its entry.
        if (rr_idx_q >= n_q) rr_idx_d = '0;
        if (n_q == '0) begin
          state_d = DECIDE;
        end else begin
          idx_d    = '0;
          best_q_d = '0;
          state_d  = RD_ID;
        end
      end
      RD_ID: begin
        address = NBR_BASE + WORD_WIDTH'(ENTRY_STRIDE) * WORD_WIDTH'(idx_q);
        state_d = RD_Q;
      end
      RD_Q: begin
        address  = QV_BASE + WORD_WIDTH'(ENTRY_STRIDE) * WORD_WIDTH'(idx_q);
        cur_id_d = mem_data_in;
        state_d  = CMP;
      end
      CMP: begin
        // Strict compare so that ties keep the lower-indexed entry.
        if (idx_q == '0 || mem_data_in > best_q_q) begin
          best_id_d = cur_id_q;
          best_q_d  = mem_data_in;
        end
        if (idx_q == rr_idx_q) begin
          rr_id_d = cur_id_q;
          rr_q_d  = mem_data_in;
        end
        idx_d   = idx_inc;
        state_d = (idx_inc < n_q) ? RD_ID : DECIDE;
      end
      DECIDE: begin
        explore = (n_q != '0) && (lfsr_q[7:0] < eps_q);
        if (explore) begin
          nexthop_d    = rr_id_q;
          next_value_d = rr_q_q;
          explored_d   = 1'b1;
          rr_idx_d     = (rr_inc == n_q) ? '0 : rr_inc;
        end else if (n_q != '0 && best_q_q > my_val_q) begin
          nexthop_d    = best_id_q;
          next_value_d = best_q_q;
          explored_d   = 1'b0;
        end else begin
          nexthop_d    = my_id_q;
          next_value_d = my_val_q;
          explored_d   = 1'b0;
        end
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
`ifdef EPSILON_DECAY_EN
        eps_d = (eps_q > epsilon_step) ? eps_q - epsilon_step : 8'd0;
`endif
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An explicit load overrides any decay in the same cycle.
    if (load_eps) eps_d = epsilon_in;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      my_id_q      <= '0;
      my_val_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      rr_idx_q     <= '0;
      cur_id_q     <= '0;
      best_id_q    <= '0;
      best_q_q     <= '0;
      rr_id_q      <= '0;
      rr_q_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      eps_q        <= '0;
      nexthop_q    <= '0;
      next_value_q <= '0;
      explored_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      my_id_q      <= my_id_d;
      my_val_q     <= my_val_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      rr_idx_q     <= rr_idx_d;
      cur_id_q     <= cur_id_d;
      best_id_q    <= best_id_d;
      best_q_q     <= best_q_d;
      rr_id_q      <= rr_id_d;
      rr_q_q       <= rr_q_d;
      lfsr_q       <= lfsr_d;
      eps_q        <= eps_d;
      nexthop_q    <= nexthop_d;
      next_value_q <= next_value_d;
      explored_q   <= explored_d;
    end
  end

  assign nexthop    = nexthop_q;
  assign next_value = next_value_q;
  assign explored   = explored_q;
  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign cstate     = {5'd0, state_q};

endmodule

// File: tb/tb_winner_policy_v3.sv
// Directed testbench for winner_policy_v3.
// A small synchronous memory model holds the neighbour table:
// IDs 7/9/11 with Q-values 3/8/8. Every other entry is zero.
module tb_winner_policy_v3;

  logic        clock, nreset, start, load_eps;
  logic [7:0]  epsilon_in, epsilon_step, cstate;
  logic [15:0] my_node_id, my_value, nbr_count, address, mem_data_in;
  logic [15:0] nexthop, next_value;
  logic        explored, done, busy;

  logic [15:0] mem [0:1023];
  int          check_count, pass_count;
  int          lat;
  logic        done_after;

  winner_policy_v3 dut (
    .clock(clock), .nreset(nreset), .start(start), .load_eps(load_eps),
    .epsilon_in(epsilon_in), .epsilon_step(epsilon_step),
    .my_node_id(my_node_id), .my_value(my_value), .nbr_count(nbr_count),
    .address(address), .mem_data_in(mem_data_in), .nexthop(nexthop),
    .next_value(next_value), .explored(explored), .done(done), .busy(busy),
    .cstate(cstate)
  );

  // Clock with a 10-time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory read data is valid one cycle after the address.
  always @(posedge clock) mem_data_in <= mem[address[10:1]];

  // Holds reset low for two clock edges, then releases it on a falling edge.
  task automatic apply_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
  endtask

  // Loads the epsilon register with a one-cycle load_eps pulse.
  task automatic set_eps(input logic [7:0] val);
    @(negedge clock);
    load_eps = 1'b1; epsilon_in = val;
    @(negedge clock);
    load_eps = 1'b0;
  endtask

  // Runs one decision. lat returns the number of edges after the start edge
  // until done is seen. done_o returns done one edge later.
  task automatic run_decision(input logic [15:0] n, input logic [15:0] id,
                              input logic [15:0] val, output int lat_o,
                              output logic done_o);
    @(negedge clock);
    nbr_count = n; my_node_id = id; my_value = val; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat_o = 0;
    do begin
      @(posedge clock); #1;
      lat_o++;
    end while (!done && lat_o < 400);
    @(posedge clock); #1;
    done_o = done;
  endtask

  // Checks the outputs while reset is held and again after it is released.
  task automatic test_reset();
    nreset = 1'b0;
    #3;
    check_count++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0h expected 0", busy); else pass_count++;
    check_count++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0h expected 0", done); else pass_count++;
    apply_reset();
    #1;
    check_count++; if (cstate !== 8'd0) $display("[TB] FAIL reset_cstate: got %0h expected 0", cstate); else pass_count++;
    check_count++; if (address !== 16'h0) $display("[TB] FAIL reset_address: got %0h expected 0", address); else pass_count++;
    check_count++; if (nexthop !== 16'h0) $display("[TB] FAIL reset_nexthop: got %0h expected 0", nexthop); else pass_count++;
    check_count++; if (next_value !== 16'h0) $display("[TB] FAIL reset_next_value: got %0h expected 0", next_value); else pass_count++;
    check_count++; if (explored !== 1'b0) $display("[TB] FAIL reset_explored: got %0h expected 0", explored); else pass_count++;
  endtask

  // Greedy pick with my_value=5. Traces the first scan states and addresses.
  // start is held high into the scan to show that it is ignored while busy.
  task automatic test_greedy();
    @(negedge clock);
    nbr_count = 16'd3; my_node_id = 16'd5; my_value = 16'd5; start = 1'b1;
    @(posedge clock); #1;
    check_count++; if (cstate !== 8'd1) $display("[TB] FAIL trace_check: got %0h expected 1", cstate); else pass_count++;
    check_count++; if (busy !== 1'b1) $display("[TB] FAIL trace_busy: got %0h expected 1", busy); else pass_count++;
    @(posedge clock); #1;
    start = 1'b0;
    check_count++; if (cstate !== 8'd2) $display("[TB] FAIL trace_rd_id: got %0h expected 2", cstate); else pass_count++;
    check_count++; if (address !== 16'h0048) $display("[TB] FAIL trace_addr_id0: got %0h expected 48", address); else pass_count++;
    @(posedge clock); #1;
    check_count++; if (address !== 16'h01C8) $display("[TB] FAIL trace_addr_q0: got %0h expected 1c8", address); else pass_count++;
    @(posedge clock); #1;
    check_count++; if (cstate !== 8'd4) $display("[TB] FAIL trace_cmp: got %0h expected 4", cstate); else pass_count++;
    @(posedge clock); #1;
    check_count++; if (address !== 16'h004A) $display("[TB] FAIL trace_addr_id1: got %0h expected 4a", address); else pass_count++;
    lat = 4;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!done && lat < 400);
    check_count++; if (lat !== 11) $display("[TB] FAIL greedy_latency: got %0d expected 11", lat); else pass_count++;
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL greedy_nexthop: got %0h expected 9", nexthop); else pass_count++;
    check_count++; if (next_value !== 16'd8) $display("[TB] FAIL greedy_value: got %0h expected 8", next_value); else pass_count++;
    check_count++; if (explored !== 1'b0) $display("[TB] FAIL greedy_explored: got %0h expected 0", explored); else pass_count++;
    @(posedge clock); #1;
    check_count++; if (done !== 1'b0) $display("[TB] FAIL greedy_done_pulse: got %0h expected 0", done); else pass_count++;
    check_count++; if (busy !== 1'b0) $display("[TB] FAIL greedy_idle: got %0h expected 0", busy); else pass_count++;
  endtask

  // Own Q-value beats every neighbour, so the node keeps itself.
  task automatic test_own_better();
    run_decision(16'd3, 16'd5, 16'd20, lat, done_after);
    check_count++; if (nexthop !== 16'd5) $display("[TB] FAIL own_nexthop: got %0h expected 5", nexthop); else pass_count++;
    check_count++; if (next_value !== 16'd20) $display("[TB] FAIL own_value: got %0h expected 14", next_value); else pass_count++;
  endtask

  // No neighbours: never explores even at full epsilon. Latency is 2 edges.
  task automatic test_zero_nbr();
    set_eps(8'hFF);
    run_decision(16'd0, 16'h0033, 16'd4, lat, done_after);
    check_count++; if (lat !== 2) $display("[TB] FAIL zero_latency: got %0d expected 2", lat); else pass_count++;
    check_count++; if (nexthop !== 16'h0033) $display("[TB] FAIL zero_nexthop: got %0h expected 33", nexthop); else pass_count++;
    check_count++; if (next_value !== 16'd4) $display("[TB] FAIL zero_value: got %0h expected 4", next_value); else pass_count++;
    check_count++; if (explored !== 1'b0) $display("[TB] FAIL zero_explored: got %0h expected 0", explored); else pass_count++;
    check_count++; if (done_after !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %0h expected 0", done_after); else pass_count++;
  endtask

  // Starts from the LFSR seed. LFSR low bytes E1,C3,87,0F all lie below FF.
  // Round robin gives 7 then 9. A shrink to N=2 with rr_idx=2 restarts at
  // entry 0 (7), then N=3 resumes at index 1 (9).
  task automatic test_explore();
    apply_reset();
    epsilon_step = 8'd0;
    set_eps(8'hFF);
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (explored !== 1'b1) $display("[TB] FAIL exp1_explored: got %0h expected 1", explored); else pass_count++;
    check_count++; if (nexthop !== 16'd7) $display("[TB] FAIL exp1_nexthop: got %0h expected 7", nexthop); else pass_count++;
    check_count++; if (next_value !== 16'd3) $display("[TB] FAIL exp1_value: got %0h expected 3", next_value); else pass_count++;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL exp2_nexthop: got %0h expected 9", nexthop); else pass_count++;
    run_decision(16'd2, 16'd5, 16'd5, lat, done_after);
    check_count++; if (lat !== 8) $display("[TB] FAIL shrink_latency: got %0d expected 8", lat); else pass_count++;
    check_count++; if (nexthop !== 16'd7) $display("[TB] FAIL shrink_nexthop: got %0h expected 7", nexthop); else pass_count++;
    check_count++; if (explored !== 1'b1) $display("[TB] FAIL shrink_explored: got %0h expected 1", explored); else pass_count++;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL exp4_nexthop: got %0h expected 9", nexthop); else pass_count++;
  endtask

`ifdef EPSILON_DECAY_EN
  // Step FF empties epsilon after one decision. A later load of eps=2 with
  // step=1 decays to 1 then 0. LFSR low bytes 79 and F2 never explore.
  task automatic test_decay();
    epsilon_step = 8'hFF;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (nexthop !== 16'd11) $display("[TB] FAIL decay1_nexthop: got %0h expected b", nexthop); else pass_count++;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (explored !== 1'b0) $display("[TB] FAIL decay2_explored: got %0h expected 0", explored); else pass_count++;
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL decay2_nexthop: got %0h expected 9", nexthop); else pass_count++;
    epsilon_step = 8'd1;
    set_eps(8'd2);
    for (int i = 0; i < 3; i++) begin
      run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
      check_count++; if (explored !== 1'b0) $display("[TB] FAIL decay_small_explored: got %0h expected 0 at %0d", explored, i); else pass_count++;
    end
    epsilon_step = 8'd0;
  endtask
`else
  // Without decay, epsilon stays at FF even with a large step.
  // LFSR low bytes 1E and 3C keep exploring: 11, then the wrap to 7.
  task automatic test_no_decay();
    epsilon_step = 8'hFF;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (nexthop !== 16'd11) $display("[TB] FAIL nodecay1_nexthop: got %0h expected b", nexthop); else pass_count++;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (explored !== 1'b1) $display("[TB] FAIL nodecay2_explored: got %0h expected 1", explored); else pass_count++;
    check_count++; if (nexthop !== 16'd7) $display("[TB] FAIL nodecay2_nexthop: got %0h expected 7", nexthop); else pass_count++;
    epsilon_step = 8'd0;
  endtask
`endif

  // nbr_count=100 clamps to 64 entries, so the latency is 3*64+2 edges.
  task automatic test_clamp();
    set_eps(8'd0);
    run_decision(16'd100, 16'd5, 16'd1, lat, done_after);
    check_count++; if (lat !== 194) $display("[TB] FAIL clamp_latency: got %0d expected 194", lat); else pass_count++;
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL clamp_nexthop: got %0h expected 9", nexthop); else pass_count++;
  endtask

  // Reset asserted during RD_Q aborts at once. The next decision is normal.
  task automatic test_reset_midscan();
    @(negedge clock);
    nbr_count = 16'd3; my_node_id = 16'd5; my_value = 16'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_count++; if (cstate !== 8'd3) $display("[TB] FAIL mid_rd_q: got %0h expected 3", cstate); else pass_count++;
    nreset = 1'b0;
    #1;
    check_count++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %0h expected 0", busy); else pass_count++;
    check_count++; if (done !== 1'b0) $display("[TB] FAIL mid_done: got %0h expected 0", done); else pass_count++;
    check_count++; if (address !== 16'h0) $display("[TB] FAIL mid_address: got %0h expected 0", address); else pass_count++;
    check_count++; if (nexthop !== 16'h0) $display("[TB] FAIL mid_nexthop: got %0h expected 0", nexthop); else pass_count++;
    @(negedge clock);
    nreset = 1'b1;
    run_decision(16'd3, 16'd5, 16'd5, lat, done_after);
    check_count++; if (lat !== 11) $display("[TB] FAIL post_latency: got %0d expected 11", lat); else pass_count++;
    check_count++; if (nexthop !== 16'd9) $display("[TB] FAIL post_nexthop: got %0h expected 9", nexthop); else pass_count++;
    check_count++; if (explored !== 1'b0) $display("[TB] FAIL post_explored: got %0h expected 0", explored); else pass_count++;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    check_count = 0; pass_count = 0;
    nreset = 1'b0; start = 1'b0; load_eps = 1'b0;
    epsilon_in = 8'd0; epsilon_step = 8'd0;
    my_node_id = 16'd0; my_value = 16'd0; nbr_count = 16'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[16'h24] = 16'd7; mem[16'h25] = 16'd9; mem[16'h26] = 16'd11;
    mem[16'hE4] = 16'd3; mem[16'hE5] = 16'd8; mem[16'hE6] = 16'd8;

    test_reset();
    test_greedy();
    test_own_better();
    test_zero_nbr();
    test_explore();
`ifdef EPSILON_DECAY_EN
    test_decay();
`else
    test_no_decay();
`endif
    test_clamp();
    test_reset_midscan();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
